// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [2*W-1:0]  req_a,
  input  logic [2*W-1:0]  req_b,
  input  logic [1:0]    req_ci,
  input  logic [2*SW-1:0] req_s,
  output logic [1:0]    resp_valid,
  input  logic [1:0]    resp_ready,
  output logic [W:0]    resp_o,
  output logic          busy,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic          alu_ci,
  output logic [SW-1:0] alu_s,
  input  logic [W:0]    alu_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic          r_rr_last;
  logic          r_rsp_id;
  logic [1:0]    r_resp_valid;
  logic [W:0]    r_resp_o;
  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  logic          r_alu_ci;
  logic [SW-1:0] r_alu_s;

  logic          w_win;
  logic          w_acc;
  logic          w_rel;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_ci;
  logic [SW-1:0] w_s;

  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    w_win = req_valid[1];
    if (&req_valid)
      w_win = ~r_rr_last;
  end

  assign w_acc = (r_state == S_IDLE) && (|req_valid);
  assign w_rel = (r_state == S_RESP) && resp_ready[r_rsp_id];

  always_comb begin
    req_ready = 2'b00;
    if (w_acc)
      req_ready[w_win] = 1'b1;
  end

  assign w_a  = w_win ? req_a[2*W-1:W]   : req_a[W-1:0];
  assign w_b  = w_win ? req_b[2*W-1:W]   : req_b[W-1:0];
  assign w_ci = w_win ? req_ci[1]        : req_ci[0];
  assign w_s  = w_win ? req_s[2*SW-1:SW] : req_s[SW-1:0];

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_nxt = S_EXEC;
      S_EXEC:  w_nxt = S_RESP;
      S_RESP:  if (w_rel) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  // All four ALU inputs load together so the ALU never sees a mixed operand set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_ci  <= 1'b0;
      r_alu_s   <= '0;
      r_rsp_id  <= 1'b0;
      r_rr_last <= 1'b1;
    end else if (w_acc) begin
      r_alu_a   <= w_a;
      r_alu_b   <= w_b;
      r_alu_ci  <= w_ci;
      r_alu_s   <= w_s;
      r_rsp_id  <= w_win;
      r_rr_last <= w_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_o     <= '0;
      r_resp_valid <= 2'b00;
    end else if (r_state == S_EXEC) begin
      r_resp_o     <= alu_o;
      r_resp_valid <= r_rsp_id ? 2'b10 : 2'b01;
    end else if (w_rel) begin
      r_resp_valid <= 2'b00;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_acc) begin
      if (!w_win && r_cnt0 != 16'hFFFF)
        r_cnt0 <= r_cnt0 + 16'd1;
      if (w_win && r_cnt1 != 16'hFFFF)
        r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif

  assign resp_valid = r_resp_valid;
  assign resp_o     = r_resp_o;
  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ci     = r_alu_ci;
  assign alu_s      = r_alu_s;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with an add/sub ALU stub.
// Grant counters are checked when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int SW = 3;

  typedef struct {
    int       id;
    logic [W:0] o;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [1:0]    req_ci;
  logic [2*SW-1:0] req_s;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [W:0]    resp_o;
  logic          busy;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_ci;
  logic [SW-1:0] alu_s;
  logic [W:0]    alu_o;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   gnt_cnt0;
  logic [15:0]   gnt_cnt1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];

  alu_arbiter #(.W(W), .SW(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ci     (req_ci),
    .req_s      (req_s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_o     (resp_o),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ci     (alu_ci),
    .alu_s      (alu_s),
    .alu_o      (alu_o)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  always_comb begin
    alu_o = '0;
    case (alu_s)
      3'd0: alu_o = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
      3'd1: alu_o = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_o = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic ci, input logic [SW-1:0] s);
    logic [W:0] r;
    r = '0;
    if (s == 3'd0) r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    if (s == 3'd1) r = {1'b0, a} - {1'b0, b};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci,
                        input logic [SW-1:0] s);
    req_a[id*W +: W]   = a;
    req_b[id*W +: W]   = b;
    req_ci[id]         = ci;
    req_s[id*SW +: SW] = s;
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id = id;
    e.o  = model(req_a[id*W +: W], req_b[id*W +: W],
                 req_ci[id], req_s[id*SW +: SW]);
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("resp_owner", {30'd0, resp_valid}, 32'd1 << e.id);
      chk("resp_o", {23'd0, resp_o}, {23'd0, e.o});
    end
  endtask

  task automatic do_op(input int id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci,
                       input logic [SW-1:0] s);
    @(negedge clk);
    set_op(id, a, b, ci, s);
    req_valid  = 2'b01 << id;
    resp_ready = 2'b00;
    #1;
    chk("op_req_ready", {30'd0, req_ready}, 32'd1 << id);
    push(id);
    @(negedge clk);
    req_valid = 2'b00;
    chk("op_alu_a", {24'd0, alu_a}, {24'd0, a});
    chk("op_alu_b", {24'd0, alu_b}, {24'd0, b});
    chk("op_alu_ci", {31'd0, alu_ci}, {31'd0, ci});
    chk("op_alu_s", {29'd0, alu_s}, {29'd0, s});
    chk("op_exec_busy", {31'd0, busy}, 32'd1);
    chk("op_exec_rv", {30'd0, resp_valid}, 32'd0);
    @(negedge clk);
    pop_chk();
    resp_ready = 2'b01 << id;
    @(negedge clk);
    resp_ready = 2'b00;
    chk("op_done_rv", {30'd0, resp_valid}, 32'd0);
    chk("op_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W:0] held;
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_ci     = 2'b00;
    req_s      = '0;
    resp_ready = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_o", {23'd0, resp_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu", {20'd0, alu_a, alu_b, alu_ci, alu_s}, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_cnt", {gnt_cnt0, gnt_cnt1}, 32'd0);
`endif
    rst_n = 1'b1;

    do_op(0, 8'h8C, 8'h13, 1'b1, 3'd0);
    do_op(1, 8'hFF, 8'h01, 1'b1, 3'd0);

    // Both requesters valid continuously: grants alternate
    @(negedge clk);
    set_op(0, 8'h31, 8'h22, 1'b1, 3'd0);
    set_op(1, 8'h40, 8'h15, 1'b0, 3'd1);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_grant", {30'd0, req_ready}, 32'd1 << (k % 2));
      chk("tie_idle_busy", {31'd0, busy}, 32'd0);
      push(k % 2);
      @(negedge clk);
      chk("tie_exec_busy", {31'd0, busy}, 32'd1);
      chk("tie_exec_rdy", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      pop_chk();
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    chk("tie_end_busy", {31'd0, busy}, 32'd0);

    // r0 response held off while r1 waits
    @(negedge clk);
    set_op(0, 8'h40, 8'h55, 1'b0, 3'd1);
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    #1;
    chk("bp_grant0", {30'd0, req_ready}, 32'd1);
    push(0);
    @(negedge clk);
    set_op(1, 8'h12, 8'h34, 1'b0, 3'd0);
    req_valid = 2'b10;
    #1;
    chk("bp_exec_rdy", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    resp_ready = 2'b10;
    held = resp_o;
    pop_chk();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rv_held", {30'd0, resp_valid}, 32'd1);
      chk("bp_o_stable", {23'd0, resp_o}, {23'd0, held});
      chk("bp_rdy1_low", {30'd0, req_ready}, 32'd0);
      if (c == 4) resp_ready = 2'b01;
      @(negedge clk);
    end
    #1;
    chk("bp_grant1", {30'd0, req_ready}, 32'd2);
    chk("bp_rv_clear", {30'd0, resp_valid}, 32'd0);
    push(1);
    resp_ready = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    pop_chk();
    @(negedge clk);
    resp_ready = 2'b00;

    // Reset during EXEC drops the op and restores tie priority to r0
    @(negedge clk);
    set_op(0, 8'h77, 8'h11, 1'b1, 3'd0);
    req_valid = 2'b01;
    #1;
    chk("rm_grant0", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rm_exec_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_rv", {30'd0, resp_valid}, 32'd0);
    chk("rm_o", {23'd0, resp_o}, 32'd0);
    chk("rm_alu", {20'd0, alu_a, alu_b, alu_ci, alu_s}, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rm_cnt", {gnt_cnt0, gnt_cnt1}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_resp", {30'd0, resp_valid}, 32'd0);
    end
    set_op(0, 8'h05, 8'h06, 1'b0, 3'd0);
    set_op(1, 8'h09, 8'h02, 1'b0, 3'd1);
    req_valid = 2'b11;
    #1;
    chk("rm_tie_r0", {30'd0, req_ready}, 32'd1);
    push(0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    pop_chk();
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;

`ifdef ALU_ARB_STATS_EN
    do_op(0, 8'h01, 8'h02, 1'b0, 3'd0);
    do_op(1, 8'h03, 8'h04, 1'b0, 3'd0);
    do_op(0, 8'h05, 8'h06, 1'b0, 3'd1);
    do_op(1, 8'h07, 8'h08, 1'b1, 3'd0);
    chk("cnt0", {16'd0, gnt_cnt0}, 32'd3);
    chk("cnt1", {16'd0, gnt_cnt1}, 32'd2);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
